// File: rtl/nibbler_pc_stack.sv
// Program counter with fetch/execute phasing and a small return-address stack.
// Handles INC, conditional/unconditional jumps, CALL and RET with sticky error flags.

module nibbler_pc_stack_entry #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module nibbler_pc_stack #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic              c_flag,
    input  logic              z_flag,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] pc,
    output logic              phase,
    output logic [4:0]        sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_ovf,
    output logic              stack_unf
);
    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JC   = 3'b010;
    localparam logic [2:0] OP_JNC  = 3'b011;
    localparam logic [2:0] OP_JZ   = 3'b100;
    localparam logic [2:0] OP_JNZ  = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    typedef struct packed {
        logic push;
        logic ovf_set;
        logic unf_set;
    } ctl_t;

    logic [STACK_DEPTH-1:0][ADDR_W-1:0] entry_q;
    logic [STACK_DEPTH-1:0]             entry_we;
    logic [ADDR_W-1:0]                  pc_inc;
    logic [ADDR_W-1:0]                  pc_nxt;
    logic [ADDR_W-1:0]                  top_q;
    logic [4:0]                         sp_nxt;
    logic                               exec;
    ctl_t                               ctl;

    assign pc_inc      = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign exec        = enable & phase;
    assign stack_full  = (sp == 5'(STACK_DEPTH));
    assign stack_empty = (sp == 5'd0);

    // Only the entry just below sp is ever read, so stale entries stay hidden.
    always_comb begin
        top_q = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (5'(i) == sp - 5'd1) top_q = entry_q[i];
    end

    always_comb begin
        pc_nxt = pc;
        sp_nxt = sp;
        ctl    = '0;
        if (exec) begin
            unique case (op)
                OP_INC:  pc_nxt = pc_inc;
                OP_JMP:  pc_nxt = target;
                OP_JC:   pc_nxt = c_flag  ? target : pc_inc;
                OP_JNC:  pc_nxt = !c_flag ? target : pc_inc;
                OP_JZ:   pc_nxt = z_flag  ? target : pc_inc;
                OP_JNZ:  pc_nxt = !z_flag ? target : pc_inc;
                OP_CALL: begin
                    if (stack_full) begin
                        pc_nxt      = pc_inc;
                        ctl.ovf_set = 1'b1;
                    end else begin
                        pc_nxt   = target;
                        sp_nxt   = sp + 5'd1;
                        ctl.push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc_nxt      = pc_inc;
                        ctl.unf_set = 1'b1;
                    end else begin
                        pc_nxt = top_q;
                        sp_nxt = sp - 5'd1;
                    end
                end
                default: pc_nxt = pc;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < STACK_DEPTH; g++) begin : g_entry
            assign entry_we[g] = ctl.push && (sp == 5'(g));
            nibbler_pc_stack_entry #(.ADDR_W(ADDR_W)) u_entry (
                .clock (clock),
                .reset (reset),
                .we    (entry_we[g]),
                .d     (pc_inc),
                .q     (entry_q[g])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            phase <= 1'b0;
            sp    <= '0;
        end else if (enable) begin
            pc    <= pc_nxt;
            phase <= ~phase;
            sp    <= sp_nxt;
        end
    end

    // A fresh error on the same edge beats clear_err.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (ctl.ovf_set)    stack_ovf <= 1'b1;
            else if (clear_err) stack_ovf <= 1'b0;
            if (ctl.unf_set)    stack_unf <= 1'b1;
            else if (clear_err) stack_unf <= 1'b0;
        end
    end
endmodule
